// File: rtl/serial_subtractor_if.sv
// Valid/ready operand and result bundle for the digit-serial subtractor.
// master drives operands and result acceptance; slave is the subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, borrow, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, borrow, ovf, busy
  );
endinterface

// File: rtl/serial_subtractor.sv
// Digit-serial A - B - bin: DIGIT bits per clock, LSB digit first, with a
// borrow chained between digits and a held result behind a valid/ready port.
module serial_subtractor #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             a_msb;
  logic             b_msb;
  logic             brw;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [DIGIT:0]         d;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0]       res_next;
  logic                   ovf_next;

  // One digit at DIGIT+1 bits; the top bit is set exactly when the digit underflows.
  function automatic logic [DIGIT:0] sub_digit(input logic [DIGIT-1:0] x,
                                               input logic [DIGIT-1:0] y,
                                               input logic             br);
    return {1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, br};
  endfunction

  assign d        = sub_digit(a_sh[DIGIT-1:0], b_sh[DIGIT-1:0], brw);
  // New digit enters at the top; concatenating avoids an empty slice when N == 1.
  assign res_cat  = {d[DIGIT-1:0], res};
  assign res_next = res_cat[WIDTH+DIGIT-1:DIGIT];
  assign ovf_next = (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      a_sh        <= '0;
      b_sh        <= '0;
      a_msb       <= 1'b0;
      b_msb       <= 1'b0;
      brw         <= 1'b0;
      res         <= '0;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_ready_q && bus.in_valid) begin
            a_sh       <= bus.a;
            b_sh       <= bus.b;
            brw        <= bus.bin;
            a_msb      <= bus.a[WIDTH-1];
            b_msb      <= bus.b[WIDTH-1];
            cnt        <= '0;
            res        <= '0;
            in_ready_q <= 1'b0;
            state      <= CALC;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        CALC: begin
          a_sh <= a_sh >> DIGIT;
          b_sh <= b_sh >> DIGIT;
          brw  <= d[DIGIT];
          res  <= res_next;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            diff_q      <= res_next;
            borrow_q    <= d[DIGIT];
            ovf_q       <= ovf_next;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;
  assign bus.ovf       = ovf_q;
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=16, DIGIT=4) against an
// arithmetic reference model with directed and randomised valid/ready traffic.
module tb_serial_subtractor;
  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int N     = WIDTH / DIGIT;
  localparam int OPS   = 1000;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  logic [17:0] exp_q[$];
  int          consumed;
  int          accepted;
  bit          b2b_done;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {diff, borrow, ovf} from plain integer arithmetic
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic bin);
    int ua, ub, ud, sd;
    logic [15:0] df;
    logic br, ov;
    ua = int'(a);
    ub = int'(b);
    ud = ua - ub - int'(bin);
    df = ud[15:0];
    br = (ua < ub + int'(bin));
    sd = int'($signed(a)) - int'($signed(b)) - int'(bin);
    ov = (sd > 32767) || (sd < -32768);
    return {df, br, ov};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    bus.a        = 16'h0;
    bus.b        = 16'h0;
    bus.bin      = 1'b0;
    bus.out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.diff, bus.borrow, bus.ovf} !== 21'h0) begin
      fails++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b busy=%b diff=%h brw=%b ovf=%b, expected all 0",
               bus.in_ready, bus.out_valid, bus.busy, bus.diff, bus.borrow, bus.ovf);
    end
    bus.in_valid = 1'b1;
    tick();
    tick();
    tests++;
    if (bus.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold_ready: got %b expected 0", bus.in_ready);
    end
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    #2;
    tests++;
    if (bus.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL ready_before_edge: got %b expected 0", bus.in_ready);
    end
    tick();
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_after_release: got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_directed_op(input string name, input logic [15:0] a,
                                  input logic [15:0] b, input logic bin);
    logic [17:0] exp;
    int k;
    exp = model(a, b, bin);
    bus.out_ready = 1'b1;
    k = 0;
    while (!bus.in_ready && k < 20) begin
      tick();
      k++;
    end
    bus.a = a;
    bus.b = b;
    bus.bin = bin;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.a = ~a;
    bus.b = a ^ b;
    bus.bin = ~bin;
    tests++;
    if ({bus.in_ready, bus.busy} !== 2'b01) begin
      fails++;
      $display("FAIL %s_accept: got rdy=%b busy=%b expected rdy=0 busy=1", name, bus.in_ready, bus.busy);
    end
    k = 0;
    while (!bus.out_valid && k < 20) begin
      tick();
      k++;
    end
    tests++;
    if (k !== N) begin
      fails++;
      $display("FAIL %s_latency: got %0d edges expected %0d", name, k, N);
    end
    tests++;
    if ({bus.diff, bus.borrow, bus.ovf} !== exp) begin
      fails++;
      $display("FAIL %s_result: got diff=%h brw=%b ovf=%b expected diff=%h brw=%b ovf=%b",
               name, bus.diff, bus.borrow, bus.ovf, exp[17:2], exp[1], exp[0]);
    end
    tick();
    tests++;
    if ({bus.out_valid, bus.in_ready, bus.busy, bus.diff, bus.borrow, bus.ovf} !== {3'b010, exp}) begin
      fails++;
      $display("FAIL %s_release: got vld=%b rdy=%b busy=%b diff=%h expected vld=0 rdy=1 busy=0 diff=%h",
               name, bus.out_valid, bus.in_ready, bus.busy, bus.diff, exp[17:2]);
    end
  endtask

  task automatic test_arith();
    test_directed_op("basic",     16'h1234, 16'h0034, 1'b0);
    test_directed_op("underflow", 16'h0000, 16'h0001, 1'b0);
    test_directed_op("overflow",  16'h8000, 16'h0001, 1'b0);
    test_directed_op("bin_wrap",  16'h0000, 16'hFFFF, 1'b1);
    test_directed_op("bin_ovf",   16'h8000, 16'h0000, 1'b1);
  endtask

  task automatic test_backpressure();
    logic [17:0] exp;
    int k;
    exp = model(16'hA5C3, 16'h5A3C, 1'b1);
    bus.out_ready = 1'b0;
    k = 0;
    while (!bus.in_ready && k < 20) begin
      tick();
      k++;
    end
    bus.a = 16'hA5C3;
    bus.b = 16'h5A3C;
    bus.bin = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    k = 0;
    while (!bus.out_valid && k < 20) begin
      tick();
      k++;
    end
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = ~bus.in_valid;
      bus.a = 16'($urandom);
      bus.b = 16'($urandom);
      bus.bin = 1'($urandom_range(0, 1));
      tick();
      tests++;
      if ({bus.out_valid, bus.in_ready, bus.busy, bus.diff, bus.borrow, bus.ovf} !== {3'b101, exp}) begin
        fails++;
        $display("FAIL backpressure_hold: cycle %0d got vld=%b rdy=%b busy=%b diff=%h expected vld=1 rdy=0 busy=1 diff=%h",
                 i, bus.out_valid, bus.in_ready, bus.busy, bus.diff, exp[17:2]);
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tests++;
    if ({bus.out_valid, bus.in_ready, bus.diff} !== {2'b01, exp[17:2]}) begin
      fails++;
      $display("FAIL backpressure_release: got vld=%b rdy=%b diff=%h expected vld=0 rdy=1 diff=%h",
               bus.out_valid, bus.in_ready, bus.diff, exp[17:2]);
    end
    tick();
    tests++;
    if (bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL backpressure_no_accept: got busy=%b expected 0", bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    exp_q.delete();
    consumed = 0;
    accepted = 0;
    b2b_done = 1'b0;
    fork
      begin : producer
        for (int i = 0; i < OPS; i++) begin
          bit acc;
          int w;
          bus.in_valid = 1'b0;
          bus.a = 16'($urandom);
          bus.b = 16'($urandom);
          repeat ($urandom_range(0, 2)) tick();
          bus.a = 16'($urandom);
          bus.b = 16'($urandom);
          bus.bin = 1'($urandom_range(0, 1));
          bus.in_valid = 1'b1;
          acc = 1'b0;
          w = 0;
          while (!acc && w < 100) begin
            @(negedge clk);
            acc = bus.in_ready;
            tick();
            w++;
          end
          if (!acc) begin
            tests++;
            fails++;
            $display("FAIL b2b_accept_timeout: op %0d not accepted within %0d cycles", i, w);
            break;
          end
        end
        bus.in_valid = 1'b0;
      end
      begin : consumer
        while (!b2b_done) begin
          bus.out_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
        bus.out_ready = 1'b1;
      end
      begin : monitor
        int cyc;
        logic [17:0] exp;
        cyc = 0;
        while (consumed < OPS && cyc < 40000) begin
          @(negedge clk);
          cyc++;
          if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(model(bus.a, bus.b, bus.bin));
            accepted++;
          end
          if (bus.out_valid && bus.out_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
              fails++;
              $display("FAIL b2b_spurious_result: got diff=%h with no pending operation", bus.diff);
            end else begin
              exp = exp_q.pop_front();
              if ({bus.diff, bus.borrow, bus.ovf} !== exp) begin
                fails++;
                $display("FAIL b2b_result: op %0d got diff=%h brw=%b ovf=%b expected diff=%h brw=%b ovf=%b",
                         consumed, bus.diff, bus.borrow, bus.ovf, exp[17:2], exp[1], exp[0]);
              end
            end
            consumed++;
          end
        end
        b2b_done = 1'b1;
      end
    join
    tests++;
    if (accepted !== OPS || consumed !== OPS || exp_q.size() != 0) begin
      fails++;
      $display("FAIL b2b_counts: got accepted=%0d consumed=%0d pending=%0d expected %0d/%0d/0",
               accepted, consumed, exp_q.size(), OPS, OPS);
    end
    tick();
    tick();
  endtask

  task automatic test_reset_mid_op();
    int k;
    bus.out_ready = 1'b1;
    k = 0;
    while (!bus.in_ready && k < 20) begin
      tick();
      k++;
    end
    bus.a = 16'h1234;
    bus.b = 16'h4321;
    bus.bin = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tests++;
    if (bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL midreset_busy: got %b expected 1", bus.busy);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.diff, bus.borrow, bus.ovf} !== 21'h0) begin
      fails++;
      $display("FAIL midreset_outputs: got rdy=%b vld=%b busy=%b diff=%h brw=%b ovf=%b, expected all 0",
               bus.in_ready, bus.out_valid, bus.busy, bus.diff, bus.borrow, bus.ovf);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tests++;
    if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin
      fails++;
      $display("FAIL midreset_recover: got rdy=%b vld=%b busy=%b expected rdy=1 vld=0 busy=0",
               bus.in_ready, bus.out_valid, bus.busy);
    end
    test_directed_op("after_reset", 16'h00FF, 16'h0F0F, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_arith();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
